// File: rtl/ddr_reader_pkg.sv
// Shared types and constants for the DDR frame reader.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package ddr_reader_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    WAIT_CAL,
    IDLE,
    RUN,
    FLUSH
  } rd_state_t;

  // MIG user-port instruction encoding for a read.
  localparam logic [2:0] CMD_READ = 3'b001;

  // One DDR word carries one pixel's iteration count.
  localparam int BYTES_PER_WORD = 4;

  // Palette ROM shape. Red ramps with the index, green is the index
  // scrambled by a constant, and blue is the inverted ramp.
  localparam int         PAL_ENTRIES = 256;
  localparam logic [7:0] PAL_G_XOR   = 8'h5A;

  // Palette ROM contents as a pure function of the index.
  function automatic logic [23:0] palette_color(input logic [7:0] idx);
    return {idx, idx ^ PAL_G_XOR, ~idx};
  endfunction

endpackage

// File: rtl/pixel_mapper.sv
// Maps one DDR iteration word to an output pixel and holds the output register.
// Latency: 1 cycle push->pix_valid (2 with DDR_FRAME_READER_PALETTE_EN).
// Backpressure: can_push drops when the output stage(s) are full and pix_ready is low.
module pixel_mapper
  import ddr_reader_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PIX_W      = 24,
  parameter int ESCAPE_VAL = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] word,
  input  logic              pix_ready,
  output logic              can_push,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid
);

  logic is_escape;
  logic advance;

  assign is_escape = (word == DATA_W'(ESCAPE_VAL));
  // The output register may take new data when it is empty or being drained.
  assign advance   = !pix_valid || pix_ready;

`ifdef DDR_FRAME_READER_PALETTE_EN

  logic        s1_valid;
  logic        s1_escape;
  logic [23:0] s1_color;

  // Stage 1 can refill whenever it is empty or about to move forward.
  assign can_push = !s1_valid || advance;

  // Stage 1: registered palette lookup plus the escape flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_escape <= 1'b0;
      s1_color  <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
    end else if (push) begin
      s1_valid  <= 1'b1;
      s1_escape <= is_escape;
      s1_color  <= palette_color(word[7:0]);
    end else if (advance) begin
      s1_valid  <= 1'b0;
    end
  end

  // Stage 2: output register, escape forces black.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else if (flush) begin
      pix_valid <= 1'b0;
    end else if (advance) begin
      pix_valid <= s1_valid;
      if (s1_valid) begin
        pix_data <= s1_escape ? '0 : PIX_W'(s1_color);
      end
    end
  end

`else

  assign can_push = advance;

  // Output register: escape value is black, everything else white.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else if (flush) begin
      pix_valid <= 1'b0;
    end else if (push) begin
      pix_valid <= 1'b1;
      pix_data  <= is_escape ? '0 : '1;
    end else if (pix_ready) begin
      pix_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: rtl/ddr_frame_reader.sv
// Streams one frame of DDR iteration words through the MIG read port as pixels.
// Latency: 1 cycle rd_en->pix_valid (2 with DDR_FRAME_READER_PALETTE_EN).
// Backpressure: pix_ready low stalls rd_en; command issue is limited by read-FIFO credit.
module ddr_frame_reader
  import ddr_reader_pkg::*;
#(
  parameter int                ADDR_W     = 30,
  parameter int                DATA_W     = 32,
  parameter int                PIX_W      = 24,
  parameter int                CNT_W      = 21,
  parameter int                MAX_BURST  = 64,
  parameter int                RD_DEPTH   = 64,
  parameter logic [ADDR_W-1:0] BASE0      = '0,
  parameter logic [ADDR_W-1:0] BASE1      = ADDR_W'(32'h0050_0000),
  parameter int                ESCAPE_VAL = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_calib_done,
  input  logic              frame_start,
  input  logic              base_select,
  input  logic [CNT_W-1:0]  frame_pixels,
  output logic              cmd_en,
  output logic [2:0]        cmd_instr,
  output logic [5:0]        cmd_bl,
  output logic [ADDR_W-1:0] cmd_byte_addr,
  input  logic              cmd_full,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_empty,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              frame_done,
  output logic              busy
);

  // Outstanding words never exceed RD_DEPTH, so one extra bit holds the full count.
  localparam int OUT_W = $clog2(RD_DEPTH) + 1;

  logic              cal_s1;
  logic              cal_s2;
  rd_state_t         state;
  rd_state_t         state_nxt;

  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  ptr;
  logic [CNT_W-1:0]  remaining_cmd;
  logic [CNT_W-1:0]  remaining_pix;
  logic [CNT_W-1:0]  burst_len;
  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W-1:0]  out_inc;
  logic [OUT_W-1:0]  out_dec;

  // Frame parameters captured on an abort, applied once the flush drains.
  logic              rs_sel;
  logic [CNT_W-1:0]  rs_pix;
  logic              restart_sel;
  logic [CNT_W-1:0]  restart_pix;

  logic              issue;
  logic              accept;
  logic              start_go;
  logic              start_zero;
  logic              abort;
  logic              last_acc;
  logic              flush_done;
  logic              restart_go;
  logic              restart_zero;
  logic              can_push;
  logic              push;
  logic              flush;

  assign cmd_instr = CMD_READ;

  // A restart request arriving in the same cycle the flush drains still wins.
  assign restart_sel  = frame_start ? base_select  : rs_sel;
  assign restart_pix  = frame_start ? frame_pixels : rs_pix;

  assign start_go     = (state == IDLE) && frame_start && (frame_pixels != '0);
  assign start_zero   = (state == IDLE) && frame_start && (frame_pixels == '0);
  assign abort        = (state == RUN)  && frame_start;
  assign accept       = pix_valid && pix_ready;
  assign last_acc     = (state == RUN) && !frame_start && accept && (remaining_pix == CNT_W'(1));
  assign flush_done   = (state == FLUSH) && (outstanding == '0);
  assign restart_go   = flush_done && (restart_pix != '0);
  assign restart_zero = flush_done && (restart_pix == '0);

  // Next burst is a full MAX_BURST except for the frame's tail.
  assign burst_len = (remaining_cmd > CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST) : remaining_cmd;

  // Only issue when the whole burst is guaranteed room in the MIG read FIFO.
  assign issue = (state == RUN) && !frame_start && (remaining_cmd != '0) && !cmd_full &&
                 !cmd_en && ((32'(outstanding) + 32'(burst_len)) <= 32'(RD_DEPTH));

  // In RUN pop only into free output space; in FLUSH discard as fast as data arrives.
  assign rd_en = !rd_empty && (outstanding != '0) &&
                 (((state == RUN) && !frame_start && can_push) || (state == FLUSH));

  assign push  = rd_en && (state == RUN);
  assign flush = abort || (state == FLUSH);

  assign out_inc = issue ? OUT_W'(burst_len) : '0;
  assign out_dec = rd_en ? OUT_W'(1) : '0;

  // Two-flop synchroniser for the asynchronous calibration flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cal_s1 <= 1'b0;
      cal_s2 <= 1'b0;
    end else begin
      cal_s1 <= mem_calib_done;
      cal_s2 <= cal_s1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_CAL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the busy flag.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      WAIT_CAL: begin
        if (cal_s2) state_nxt = IDLE;
      end
      IDLE: begin
        if (start_go) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (frame_start)   state_nxt = FLUSH;
        else if (last_acc) state_nxt = IDLE;
      end
      FLUSH: begin
        busy = 1'b1;
        if (flush_done) state_nxt = restart_go ? RUN : IDLE;
      end
      default: state_nxt = WAIT_CAL;
    endcase
  end

  // Frame bookkeeping: base, word pointer and the two remaining counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base          <= '0;
      ptr           <= '0;
      remaining_cmd <= '0;
      remaining_pix <= '0;
    end else if (start_go) begin
      base          <= base_select ? BASE1 : BASE0;
      ptr           <= '0;
      remaining_cmd <= frame_pixels;
      remaining_pix <= frame_pixels;
    end else if (restart_go) begin
      base          <= restart_sel ? BASE1 : BASE0;
      ptr           <= '0;
      remaining_cmd <= restart_pix;
      remaining_pix <= restart_pix;
    end else begin
      if (issue) begin
        ptr           <= ptr + burst_len;
        remaining_cmd <= remaining_cmd - burst_len;
      end
      if ((state == RUN) && accept) begin
        remaining_pix <= remaining_pix - CNT_W'(1);
      end
    end
  end

  // Capture restart parameters on an abort; later requests during the flush overwrite them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_sel <= 1'b0;
      rs_pix <= '0;
    end else if (frame_start && ((state == RUN) || (state == FLUSH))) begin
      rs_sel <= base_select;
      rs_pix <= frame_pixels;
    end
  end

  // Words requested from DDR but not yet popped from the read FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + out_inc - out_dec;
    end
  end

  // Command port: one-cycle strobe with length and address held until the next issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_en        <= 1'b0;
      cmd_bl        <= '0;
      cmd_byte_addr <= '0;
    end else begin
      cmd_en <= issue;
      if (issue) begin
        cmd_bl        <= 6'(burst_len - CNT_W'(1));
        cmd_byte_addr <= base + ADDR_W'(ptr) * ADDR_W'(BYTES_PER_WORD);
      end
    end
  end

  // Completion pulse: last pixel accepted, or an empty frame requested.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= start_zero || last_acc || restart_zero;
    end
  end

  pixel_mapper #(
    .DATA_W     (DATA_W),
    .PIX_W      (PIX_W),
    .ESCAPE_VAL (ESCAPE_VAL)
  ) u_mapper (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .word      (rd_data),
    .pix_ready (pix_ready),
    .can_push  (can_push),
    .pix_data  (pix_data),
    .pix_valid (pix_valid)
  );

endmodule
